spiflash_responder: RTL and testbench

Oversampled single-SPI flash responder: the device end of the flash bus that the SoC's flash controller drives. It watches `flash_csb`/`flash_clk`/`flash_io0`, decodes read and ID commands, and shifts data out on `flash_io1` from an internal byte memory. It is used as a synthesizable flash stand-in for simulation and for FPGA loopback rigs. Host-side preload is done through a simple valid/ready byte port.

---
 rtl/spiflash_responder.sv | 155 +++++++++++++++
 tb/tb_spiflash_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_responder.sv
// spiflash_responder: oversampled single-SPI flash device (0x03 read, 0x9F ID, 0xAB ignored) with host preload port.
// Define SPIFLASH_FASTREAD_EN to add 0x0B fast read with 8 dummy clocks.
module spiflash_responder #(
   parameter int          MEM_BYTES = 4096,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flash_csb,
   input  logic        flash_clk,
   input  logic        flash_io0_di,
   output logic        flash_io1_do,
   output logic        flash_io1_oe,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_addr,
   input  logic [7:0]  load_data,
   output logic        cmd_err
);
   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR,
`ifdef SPIFLASH_FASTREAD_EN
      S_DUMMY,
`endif
      S_DATA, S_ID, S_IGN
   } state_t;

   state_t        r_state, w_next, w_after_addr;
   logic [1:0]    r_csb_s, r_sck_s, r_mosi_s;
   logic          r_csb_d, r_sck_d;
   logic [1:0]    r_settle;
   logic [4:0]    r_cnt;
   logic [22:0]   r_sh;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_out;
   logic          r_do, r_oe, r_err;
   logic [7:0]    r_mem [MEM_BYTES] = '{default: 8'hFF};
   logic          w_csb, w_sck, w_mosi, w_rise, w_fall, w_err;
   logic          w_stream, w_fetch, w_byte_end, w_unused;
   logic [23:0]   w_sh;
   logic [AW-1:0] w_faddr;
   logic [7:0]    w_id, w_fbyte;
`ifdef SPIFLASH_FASTREAD_EN
   logic          r_fast;
   assign w_after_addr = r_fast ? S_DUMMY : S_DATA;
`else
   assign w_after_addr = S_DATA;
`endif

   assign w_csb    = r_csb_s[1];
   assign w_sck    = r_sck_s[1];
   assign w_mosi   = r_mosi_s[1];
   assign w_rise   = w_sck & ~r_sck_d & ~w_csb;
   assign w_fall   = ~w_sck & r_sck_d & ~w_csb;
   assign w_sh     = {r_sh, w_mosi};
   assign w_stream = (r_state == S_DATA) || (r_state == S_ID);
   // r_addr always points at the byte currently being shifted out (ID uses it as a byte index)
   assign w_faddr  = (r_state == S_ADDR) ? w_sh[AW-1:0] : (r_state == S_CMD) ? '0 : r_addr;
   assign w_id     = (w_faddr == AW'(0)) ? JEDEC_ID[23:16] :
                     (w_faddr == AW'(1)) ? JEDEC_ID[15:8]  :
                     (w_faddr == AW'(2)) ? JEDEC_ID[7:0]   : 8'hFF;
   assign w_fbyte  = (w_next == S_ID) ? w_id : r_mem[w_faddr];
   assign w_fetch  = ((w_next != r_state) && ((w_next == S_DATA) || (w_next == S_ID))) ||
                     (w_stream && w_rise && (r_cnt[2:0] == 3'd0));
   assign w_byte_end = w_stream && w_fall && (r_cnt[2:0] == 3'd7);
   assign w_unused   = &{1'b0, load_addr, w_sh[23]};

   assign load_ready   = (r_state == S_IDLE) && w_csb && r_settle[1];
   assign flash_io1_do = r_do;
   assign flash_io1_oe = r_oe;
   assign cmd_err      = r_err;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_csb_s  <= 2'b11;
         r_sck_s  <= 2'b00;
         r_mosi_s <= 2'b00;
         r_csb_d  <= 1'b1;
         r_sck_d  <= 1'b0;
         r_settle <= 2'd0;
      end else begin
         r_csb_s  <= {r_csb_s[0], flash_csb};
         r_sck_s  <= {r_sck_s[0], flash_clk};
         r_mosi_s <= {r_mosi_s[0], flash_io0_di};
         r_csb_d  <= w_csb;
         r_sck_d  <= w_sck;
         r_settle <= r_settle + {1'b0, ~r_settle[1]};
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      w_err  = 1'b0;
      case (r_state)
         S_IDLE: w_next = (r_csb_d && !w_csb) ? S_CMD : S_IDLE;
         S_CMD: if (w_rise && r_cnt == 5'd7) begin
            if (w_sh[7:0] == 8'h03) w_next = S_ADDR;
`ifdef SPIFLASH_FASTREAD_EN
            else if (w_sh[7:0] == 8'h0B) w_next = S_ADDR;
`endif
            else if (w_sh[7:0] == 8'h9F) w_next = S_ID;
            else begin
               w_next = S_IGN;
               w_err  = (w_sh[7:0] != 8'hAB);
            end
         end
         S_ADDR: if (w_rise && r_cnt == 5'd23) w_next = w_after_addr;
`ifdef SPIFLASH_FASTREAD_EN
         S_DUMMY: if (w_rise && r_cnt == 5'd7) w_next = S_DATA;
`endif
         default: ;
      endcase
      if (w_csb) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt  <= 5'd0;
         r_sh   <= 23'd0;
         r_addr <= '0;
         r_out  <= 8'hFF;
         r_do   <= 1'b0;
         r_oe   <= 1'b0;
         r_err  <= 1'b0;
`ifdef SPIFLASH_FASTREAD_EN
         r_fast <= 1'b0;
`endif
      end else begin
         r_err <= w_err;
         r_cnt <= (w_next != r_state || r_state == S_IDLE) ? 5'd0 :
                  w_stream ? r_cnt + {4'd0, w_fall} : r_cnt + {4'd0, w_rise};
         if (w_rise && !w_stream) r_sh <= w_sh[22:0];
         if (w_fetch) r_out <= w_fbyte;
         else if (w_fall && w_stream) r_out <= {r_out[6:0], 1'b1};
         if (w_fetch || r_state == S_ADDR) r_addr <= w_faddr;
         else if (w_byte_end)
            r_addr <= (r_state == S_DATA || r_addr < AW'(3)) ? r_addr + AW'(1) : r_addr;
         if (w_csb) r_oe <= 1'b0;
         else if (w_fall && w_stream) begin
            r_do <= r_out[7];
            r_oe <= 1'b1;
         end
`ifdef SPIFLASH_FASTREAD_EN
         if (r_state == S_CMD) r_fast <= (w_sh[7:0] == 8'h0B);
`endif
      end

   always_ff @(posedge clk)
      if (load_valid && load_ready) r_mem[load_addr[AW-1:0]] <= load_data;
endmodule

// File: tb/tb_spiflash_responder.sv
// tb_spiflash_responder: vector table of SPI transactions with a byte scoreboard, plus abort/preload/reset sequences.
module tb_spiflash_responder;
   localparam int HALF = 6;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      bit          has_addr;
      bit          dummy;
      int          nb;
      bit          rd;
      logic [31:0] exp;
      int          err;
   } vec_t;

   logic        clk = 1'b0, rst = 1'b0, csb = 1'b1, sck = 1'b0, mosi = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_addr = 16'd0;
   logic [7:0]  load_data = 8'd0;
   logic        miso, oe, load_ready, cmd_err;
   int          n_cmp = 0, n_bad = 0, err_cnt = 0;
   logic [7:0]  sb_q[$];
   vec_t        vt[9];

   spiflash_responder #(.MEM_BYTES(4096), .JEDEC_ID(24'hEF4016)) dut (
      .clk(clk), .rst(rst), .flash_csb(csb), .flash_clk(sck), .flash_io0_di(mosi),
      .flash_io1_do(miso), .flash_io1_oe(oe), .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_err === 1'b1) err_cnt++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_any, output logic oe_all);
      oe_any = 1'b0;
      oe_all = 1'b1;
      rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = miso;
         oe_any |= oe;
         oe_all &= oe;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic half_bit();
      mosi = 1'b0;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic load(input logic [15:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      load_valid = 1'b1;
      load_addr = a;
      load_data = d;
      while (!load_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!load_ready) check("load timeout", 32'(load_ready), 32'd1);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0] rx, e;
      logic a, l, cmd_oe;
      int e0;
      e0 = err_cnt;
      cmd_oe = 1'b0;
      for (int k = 0; k < v.nb; k++) if (v.rd) sb_q.push_back(v.exp[31-8*k -: 8]);
      csb = 1'b0;
      repeat (HALF) @(negedge clk);
      xfer(v.op, rx, a, l);
      cmd_oe |= a;
      if (v.has_addr)
         for (int k = 2; k >= 0; k--) begin
            xfer(v.addr[8*k +: 8], rx, a, l);
            cmd_oe |= a;
         end
      if (v.dummy) begin
         xfer(8'h00, rx, a, l);
         cmd_oe |= a;
      end
      for (int k = 0; k < v.nb; k++) begin
         xfer(8'h00, rx, a, l);
         if (v.rd) begin
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
            check($sformatf("v%0d data byte %0d", idx, k), 32'(rx), 32'(e));
            check($sformatf("v%0d data oe byte %0d", idx, k), 32'(l), 32'd1);
         end else check($sformatf("v%0d ignored oe", idx), 32'(a), 32'd0);
      end
      check($sformatf("v%0d oe in command phase", idx), 32'(cmd_oe), 32'd0);
      csb = 1'b1;
      repeat (8) @(negedge clk);
      check($sformatf("v%0d cmd_err pulses", idx), 32'(err_cnt - e0), 32'(v.err));
      check($sformatf("v%0d oe after csb high", idx), 32'(oe), 32'd0);
   endtask

   initial begin
      logic [7:0] rx, e;
      logic a, l;
      int ready_hi, n;
      vt[0] = '{8'h03, 24'h000000, 1'b1, 1'b0, 4, 1'b1, 32'h11223344, 0};
      vt[1] = '{8'h03, 24'h000FFF, 1'b1, 1'b0, 2, 1'b1, 32'hA5110000, 0};
      vt[2] = '{8'h03, 24'h000002, 1'b1, 1'b0, 3, 1'b1, 32'h3344FF00, 0};
      vt[3] = '{8'h9F, 24'h000000, 1'b0, 1'b0, 4, 1'b1, 32'hEF4016FF, 0};
      vt[4] = '{8'h03, 24'h010001, 1'b1, 1'b0, 2, 1'b1, 32'h22330000, 0};
`ifdef SPIFLASH_FASTREAD_EN
      vt[5] = '{8'h0B, 24'h000001, 1'b1, 1'b1, 1, 1'b1, 32'h22000000, 0};
`else
      vt[5] = '{8'h0B, 24'h000001, 1'b1, 1'b1, 1, 1'b0, 32'h00000000, 1};
`endif
      vt[6] = '{8'hAB, 24'h000000, 1'b0, 1'b0, 1, 1'b0, 32'h00000000, 0};
      vt[7] = '{8'h5A, 24'h000000, 1'b0, 1'b0, 1, 1'b0, 32'h00000000, 1};
      vt[8] = '{8'h03, 24'h000FFE, 1'b1, 1'b0, 3, 1'b1, 32'hC3A51100, 0};

      repeat (3) @(negedge clk);
      check("reset miso", 32'(miso), 32'd0);
      check("reset oe", 32'(oe), 32'd0);
      check("reset load_ready", 32'(load_ready), 32'd0);
      check("reset cmd_err", 32'(cmd_err), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("load_ready 1 cycle after reset", 32'(load_ready), 32'd0);
      @(posedge clk); #1;
      check("load_ready 2 cycles after reset", 32'(load_ready), 32'd1);

      load(16'h0000, 8'h11);
      load(16'h0001, 8'h22);
      load(16'h0002, 8'h33);
      load(16'h0003, 8'h44);
      load(16'h0FFF, 8'hA5);
      load(16'h1FFE, 8'hC3);

      for (int i = 0; i < 9; i++) run_vec(vt[i], i);

      // abort mid-byte, then a fresh read restarts at the address given
      csb = 1'b0;
      repeat (HALF) @(negedge clk);
      xfer(8'h03, rx, a, l);
      for (int k = 0; k < 3; k++) xfer(8'h00, rx, a, l);
      for (int k = 0; k < 4; k++) half_bit();
      check("abort oe before csb rise", 32'(oe), 32'd1);
      csb = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort oe 2 cycles after csb rise", 32'(oe), 32'd1);
      @(posedge clk); #1;
      check("abort oe 3 cycles after csb rise", 32'(oe), 32'd0);
      repeat (8) @(negedge clk);
      run_vec('{8'h03, 24'h000000, 1'b1, 1'b0, 1, 1'b1, 32'h11000000, 0}, 20);

      // preload request held while the bus is busy
      @(negedge clk);
      csb = 1'b0;
      repeat (4) @(negedge clk);
      load_valid = 1'b1;
      load_addr = 16'h0010;
      load_data = 8'h77;
      ready_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (load_ready) ready_hi++;
      end
      check("load_ready while csb low", 32'(ready_hi), 32'd0);
      csb = 1'b1;
      n = 0;
      while (!load_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("load_ready after csb high", 32'(load_ready), 32'd1);
      @(negedge clk);
      load_valid = 1'b0;
      repeat (4) @(negedge clk);
      run_vec('{8'h03, 24'h000010, 1'b1, 1'b0, 1, 1'b1, 32'h77000000, 0}, 21);

      // reset in the middle of a read
      csb = 1'b0;
      repeat (HALF) @(negedge clk);
      xfer(8'h03, rx, a, l);
      for (int k = 0; k < 3; k++) xfer(8'h00, rx, a, l);
      sb_q.push_back(8'h11);
      xfer(8'h00, rx, a, l);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
      check("pre-reset data byte", 32'(rx), 32'(e));
      half_bit();
      repeat (HALF) @(negedge clk);
      check("oe before async reset", 32'(oe), 32'd1);
      #2 rst = 1'b0;
      #1 check("oe after async reset", 32'(oe), 32'd0);
      csb = 1'b1;
      sck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      run_vec(vt[0], 22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
